// File: rtl/dm_pkg.sv
//------------------------------------------------------------------------------
// Module  : dm_pkg
// Brief   : Shared constants for the data-memory controller: access-type
//           codes, exception codes and controller state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dm_pkg;

  // Access type carried on memop_i
  localparam logic [2:0] OP_W   = 3'd0;
  localparam logic [2:0] OP_H   = 3'd1;
  localparam logic [2:0] OP_HU  = 3'd2;
  localparam logic [2:0] OP_B   = 3'd3;
  localparam logic [2:0] OP_BU  = 3'd4;
  localparam logic [2:0] OP_WL  = 3'd5;
  localparam logic [2:0] OP_WR  = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  // Exception codes reported with the acknowledge
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Controller states
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2
  } dm_state_e;

endpackage

`default_nettype wire

// File: rtl/dm_align.sv
//------------------------------------------------------------------------------
// Module  : dm_align
// Brief   : Combinational byte-lane logic: store byte-enables and merged
//           word, load extraction (sign/zero extend, LWL/LWR merge) and
//           misalignment detection.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_align
  import dm_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  op_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rtold_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] store_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  // 8*k and 8*(3-k); the latter is just the inverted offset times eight
  logic [4:0]  sh_k;
  logic [4:0]  sh_rk;
  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] sdata;

  assign sh_k     = {off_i, 3'b000};
  assign sh_rk    = {~off_i, 3'b000};
  assign half     = off_i[1] ? word_i[31:16] : word_i[15:0];
  assign byte_sel = 8'(word_i >> sh_k);

  // Per access type: lane enables, lane-positioned store data, load result
  always_comb begin
    be_o       = 4'b1111;
    sdata      = wdata_i;
    load_o     = word_i;
    misalign_o = 1'b0;
    case (op_i)
      OP_H, OP_HU: begin
        be_o       = off_i[1] ? 4'b1100 : 4'b0011;
        sdata      = {2{wdata_i[15:0]}};
        load_o     = (op_i == OP_H) ? {{16{half[15]}}, half} : {16'h0000, half};
        misalign_o = off_i[0];
      end
      OP_B, OP_BU: begin
        be_o   = 4'b0001 << off_i;
        sdata  = {4{wdata_i[7:0]}};
        load_o = (op_i == OP_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
      end
      OP_WL: begin
        // Lanes 0..k receive the top k+1 bytes of rt
        be_o   = 4'b1111 >> (~off_i);
        sdata  = wdata_i >> sh_rk;
        load_o = (word_i << sh_rk) | (rtold_i & ~(32'hFFFF_FFFF << sh_rk));
      end
      OP_WR: begin
        // Lanes k..3 receive the bottom 4-k bytes of rt
        be_o   = 4'b1111 << off_i;
        sdata  = wdata_i << sh_k;
        load_o = (word_i >> sh_k) | (rtold_i & ~(32'hFFFF_FFFF >> sh_k));
      end
      default: begin
        // Word access; the reserved code behaves as a word
        misalign_o = (off_i != 2'b00);
      end
    endcase
    if (we_i) begin
      load_o = 32'h0000_0000;
    end
  end

  // Merge enabled lanes of the store data over the current word
  always_comb begin
    store_o = word_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) begin
        store_o[8*i +: 8] = sdata[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_ctrl.sv
//------------------------------------------------------------------------------
// Module  : dm_ctrl
// Brief   : MEM-stage data-memory controller with req/ack handshake,
//           configurable access latency, address exceptions and an
//           optional post-reset sequential clear of the array.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rtold_i,
  input  logic        memwrite_i,
  input  logic [2:0]  memop_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        exc_o,
  output logic [4:0]  exccode_o
);

  localparam int         IDX_W    = ADDR_W - 2;
  localparam int         DEPTH    = 1 << IDX_W;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  localparam dm_state_e  RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  dm_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rtold_q, rtold_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              exc_q, exc_d;
  logic [4:0]        exccode_q, exccode_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;

  logic [31:0]       rd_word;
  logic [3:0]        be;
  logic [31:0]       store_word;
  logic [31:0]       load_word;
  logic              misalign;
  logic              out_of_range;
  logic              exc_any;

  assign rd_word      = mem_q[addr_q[ADDR_W-1:2]];
  assign out_of_range = |(addr_q >> ADDR_W);
  assign exc_any      = misalign | out_of_range;

  dm_align u_align (
    .off_i      (addr_q[1:0]),
    .op_i       (op_q),
    .we_i       (we_q),
    .wdata_i    (wdata_q),
    .rtold_i    (rtold_q),
    .word_i     (rd_word),
    .be_o       (be),
    .store_o    (store_word),
    .load_o     (load_word),
    .misalign_o (misalign)
  );

  // Next-state, request capture, commit and array write selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rtold_d   = rtold_q;
    we_d      = we_q;
    op_d      = op_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    exc_d     = exc_q;
    exccode_d = exccode_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = 32'h0000_0000;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (&idx_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ready_q && req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          rtold_d = rtold_i;
          we_d    = memwrite_i;
          op_d    = memop_i;
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d   = ST_IDLE;
          ack_d     = 1'b1;
          exc_d     = exc_any;
          exccode_d = exc_any ? (we_q ? EXC_ADES : EXC_ADEL) : EXC_NONE;
          rdata_d   = exc_any ? 32'h0000_0000 : load_word;
          if (we_q && !exc_any) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q[ADDR_W-1:2];
            mem_wdata = store_word;
          end
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Control and output registers; an in-flight access is dropped on reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= RST_STATE;
      cnt_q     <= 3'd0;
      idx_q     <= '0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      rtold_q   <= 32'h0000_0000;
      we_q      <= 1'b0;
      op_q      <= OP_W;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      exc_q     <= 1'b0;
      exccode_q <= EXC_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rtold_q   <= rtold_d;
      we_q      <= we_d;
      op_q      <= op_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      exc_q     <= exc_d;
      exccode_q <= exccode_d;
    end
  end

  // Array write port; contents survive reset, but no write lands while it is held
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) begin
      mem_q[mem_waddr] <= mem_wdata;
`ifndef SYNTHESIS
      if (state_q == ST_BUSY) begin
        $display("*%08h <= %08h", {addr_q[31:2], 2'b00}, mem_wdata);
      end
`endif
    end
  end

  assign ready_o   = ready_q;
  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign exc_o     = exc_q;
  assign exccode_o = exccode_q;

  // be is consumed inside the merge; keep it visible for debug
  logic be_unused;
  assign be_unused = ^be;

endmodule

`default_nettype wire
